// File: rtl/synapse_event_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : synapse_event_pkg                                          |
// | Shared dispatch state encoding, idle code and handler vector helper. |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package synapse_event_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        CLEAR   = 3'd2,
        SETTLE  = 3'd3,
        SERVICE = 3'd4
    } dispatch_state_t;

    localparam logic [15:0] EVENT_IDLE_CODE = 16'hFFFF;

    // Handler table entries are 2**shift words apart; the result wraps at 16 bits.
    function automatic logic [15:0] vector_of(input logic [15:0] base,
                                              input logic [15:0] idx,
                                              input int unsigned shift);
        return base + (idx << shift);
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : event_watchdog                                              |
// | Loadable saturating up-counter with a pulse one step before all-ones.|
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module event_watchdog #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             run_i,
    output logic             expire_o
);

    localparam logic [WIDTH-1:0] LAST_BEFORE_WRAP = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (run_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Fires on the cycle whose edge brings the count to all-ones, so the
    // owner can register the pulse exactly 2**WIDTH-1 cycles after load.
    assign expire_o = run_i && !load_i && (count_q == LAST_BEFORE_WRAP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/event_dispatch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : event_dispatch_sequencer                                    |
// | Turns event_controller priority output into one-at-a-time IRQs.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module event_dispatch_sequencer
    import synapse_event_pkg::*;
#(
    parameter logic [15:0] IDLE_CODE     = EVENT_IDLE_CODE,
    parameter logic [15:0] VECTOR_BASE   = 16'h0100,
    parameter int unsigned STRIDE_LOG2   = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned WDOG_BITS     = 16
) (
    input  logic        sysclk,
    input  logic        sysreset,
    input  logic [15:0] priority_in,
    output logic        priority_load,
    output logic [15:0] clear_data,
    input  logic        enable_load,
    input  logic        enable_in,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    input  logic        irq_ack,
    input  logic        irq_done,
    output logic        busy,
    output logic [15:0] current_event,
    output logic        wdog_event
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    dispatch_state_t state_q, state_d;
    logic            enable_q, enable_d;
    logic            irq_req_q, irq_req_d;
    logic [15:0]     irq_vector_q, irq_vector_d;
    logic            priority_load_q, priority_load_d;
    logic [15:0]     clear_data_q, clear_data_d;
    logic [15:0]     current_event_q, current_event_d;
    logic            busy_q, busy_d;
    logic            wdog_event_q, wdog_event_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            done_pend_q, done_pend_d;
    logic            wd_load;
    logic            wd_expire;

    event_watchdog #(
        .WIDTH (WDOG_BITS)
    ) u_watchdog (
        .clk_i      (sysclk),
        .rst_i      (sysreset),
        .load_i     (wd_load),
        .load_val_i ('0),
        .run_i      (state_q == SERVICE),
        .expire_o   (wd_expire)
    );

    always_comb begin
        state_d         = state_q;
        enable_d        = enable_load ? enable_in : enable_q;
        irq_req_d       = irq_req_q;
        irq_vector_d    = irq_vector_q;
        priority_load_d = 1'b0;
        clear_data_d    = clear_data_q;
        current_event_d = current_event_q;
        wdog_event_d    = 1'b0;
        settle_d        = settle_q;
        done_pend_d     = done_pend_q;
        wd_load         = 1'b0;

        case (state_q)
            IDLE: begin
                done_pend_d = 1'b0;
                if (enable_q && (priority_in != IDLE_CODE)) begin
                    state_d         = REQUEST;
                    irq_req_d       = 1'b1;
                    current_event_d = priority_in;
                    irq_vector_d    = vector_of(VECTOR_BASE, priority_in, STRIDE_LOG2);
                end
            end
            REQUEST: begin
                // Acknowledge takes precedence over a simultaneous disable.
                if (irq_ack) begin
                    state_d         = CLEAR;
                    irq_req_d       = 1'b0;
                    priority_load_d = 1'b1;
                    clear_data_d    = current_event_q;
                end else if (!enable_d) begin
                    state_d   = IDLE;
                    irq_req_d = 1'b0;
                end
            end
            CLEAR: begin
                state_d  = SETTLE;
                settle_d = '0;
                if (irq_done) begin
                    done_pend_d = 1'b1;
                end
            end
            SETTLE: begin
                if (irq_done) begin
                    done_pend_d = 1'b1;
                end
                if (settle_q == SETTLE_LAST) begin
                    state_d = SERVICE;
                    wd_load = 1'b1;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            SERVICE: begin
                if (irq_done || done_pend_q) begin
                    state_d     = IDLE;
                    done_pend_d = 1'b0;
                end else if (wd_expire) begin
                    state_d      = IDLE;
                    wdog_event_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_q         <= IDLE;
            enable_q        <= 1'b0;
            irq_req_q       <= 1'b0;
            irq_vector_q    <= '0;
            priority_load_q <= 1'b0;
            clear_data_q    <= '0;
            current_event_q <= IDLE_CODE;
            busy_q          <= 1'b0;
            wdog_event_q    <= 1'b0;
            settle_q        <= '0;
            done_pend_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            enable_q        <= enable_d;
            irq_req_q       <= irq_req_d;
            irq_vector_q    <= irq_vector_d;
            priority_load_q <= priority_load_d;
            clear_data_q    <= clear_data_d;
            current_event_q <= current_event_d;
            busy_q          <= busy_d;
            wdog_event_q    <= wdog_event_d;
            settle_q        <= settle_d;
            done_pend_q     <= done_pend_d;
        end
    end

    assign priority_load = priority_load_q;
    assign clear_data    = clear_data_q;
    assign irq_req       = irq_req_q;
    assign irq_vector    = irq_vector_q;
    assign busy          = busy_q;
    assign current_event = current_event_q;
    assign wdog_event    = wdog_event_q;

endmodule
`default_nettype wire

// File: tb/tb_event_dispatch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_event_dispatch_sequencer                                 |
// | Directed and randomized scenarios against a timeline reference.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_event_dispatch_sequencer;

    logic        sysclk = 1'b0;
    logic        sysreset;
    logic [15:0] priority_in;
    logic        priority_load;
    logic [15:0] clear_data;
    logic        enable_load;
    logic        enable_in;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic        irq_ack;
    logic        irq_done;
    logic        busy;
    logic [15:0] current_event;
    logic        wdog_event;

    int checks   = 0;
    int failures = 0;

    always #5 sysclk = ~sysclk;

    event_dispatch_sequencer #(
        .WDOG_BITS (4)
    ) dut (
        .sysclk        (sysclk),
        .sysreset      (sysreset),
        .priority_in   (priority_in),
        .priority_load (priority_load),
        .clear_data    (clear_data),
        .enable_load   (enable_load),
        .enable_in     (enable_in),
        .irq_req       (irq_req),
        .irq_vector    (irq_vector),
        .irq_ack       (irq_ack),
        .irq_done      (irq_done),
        .busy          (busy),
        .current_event (current_event),
        .wdog_event    (wdog_event)
    );

    // Handler address: base 0x0100 plus four words per event number.
    function automatic logic [15:0] exp_vec(input logic [15:0] e);
        return 16'h0100 + (e * 16'd4);
    endfunction

    task automatic step;
        @(negedge sysclk);
    endtask

    task automatic write_enable(input logic v);
        enable_load = 1'b1;
        enable_in   = v;
        step;
        enable_load = 1'b0;
    endtask

    task automatic test_reset;
        sysreset    = 1'b1;
        priority_in = 16'hFFFF;
        enable_load = 1'b0;
        enable_in   = 1'b0;
        irq_ack     = 1'b0;
        irq_done    = 1'b0;
        step;
        step;
        checks++;
        if (irq_req !== 1'b0 || irq_vector !== 16'h0000 || priority_load !== 1'b0 ||
            clear_data !== 16'h0000 || current_event !== 16'hFFFF || busy !== 1'b0 ||
            wdog_event !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: req=%b vec=%h pl=%b cd=%h ce=%h busy=%b wd=%b required 0 0000 0 0000 ffff 0 0",
                     irq_req, irq_vector, priority_load, clear_data, current_event, busy, wdog_event);
        end
        sysreset = 1'b0;
        step;
    endtask

    task automatic test_disabled;
        priority_in = 16'd3;
        for (int i = 0; i < 100; i++) begin
            step;
            checks++;
            if (irq_req !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL disabled_no_irq cycle %0d: req=%b busy=%b required 0 0", i, irq_req, busy);
            end
        end
    endtask

    task automatic test_dispatch_stale;
        enable_load = 1'b1;
        enable_in   = 1'b1;
        step;
        enable_load = 1'b0;
        checks++;
        if (irq_req !== 1'b0) begin
            failures++;
            $display("FAIL irq_latency_early: req=%b required 0", irq_req);
        end
        step;
        checks++;
        if (irq_req !== 1'b1 || irq_vector !== 16'h010C || current_event !== 16'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_dispatch: req=%b vec=%h ce=%0d busy=%b required 1 010c 3 1",
                     irq_req, irq_vector, current_event, busy);
        end
        irq_ack = 1'b1;
        step;
        irq_ack = 1'b0;
        priority_in = 16'd5;
        checks++;
        if (priority_load !== 1'b1 || clear_data !== 16'd3 || irq_req !== 1'b0) begin
            failures++;
            $display("FAIL clear_strobe: pl=%b cd=%0d req=%b required 1 3 0", priority_load, clear_data, irq_req);
        end
        for (int i = 0; i < 6; i++) begin
            step;
            checks++;
            if (priority_load !== 1'b0 || irq_req !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL stale_ignored cycle %0d: pl=%b req=%b busy=%b required 0 0 1",
                         i, priority_load, irq_req, busy);
            end
        end
        irq_done = 1'b1;
        step;
        irq_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || irq_req !== 1'b0) begin
            failures++;
            $display("FAIL done_to_idle: busy=%b req=%b required 0 0", busy, irq_req);
        end
        step;
        checks++;
        if (irq_req !== 1'b1 || irq_vector !== 16'h0114 || current_event !== 16'd5) begin
            failures++;
            $display("FAIL second_dispatch: req=%b vec=%h ce=%0d required 1 0114 5", irq_req, irq_vector, current_event);
        end
        irq_ack = 1'b1;
        step;
        irq_ack = 1'b0;
        priority_in = 16'hFFFF;
        checks++;
        if (priority_load !== 1'b1 || clear_data !== 16'd5) begin
            failures++;
            $display("FAIL second_clear: pl=%b cd=%0d required 1 5", priority_load, clear_data);
        end
        step;
        step;
        step;
        irq_done = 1'b1;
        step;
        irq_done = 1'b0;
    endtask

    task automatic test_enable_drop;
        priority_in = 16'd7;
        step;
        checks++;
        if (irq_req !== 1'b1) begin
            failures++;
            $display("FAIL drop_setup_req: req=%b required 1", irq_req);
        end
        write_enable(1'b0);
        checks++;
        if (irq_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop: req=%b busy=%b required 0 0", irq_req, busy);
        end
        for (int i = 0; i < 5; i++) begin
            step;
            checks++;
            if (priority_load !== 1'b0 || irq_req !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL drop_no_clear cycle %0d: pl=%b req=%b busy=%b required 0 0 0",
                         i, priority_load, irq_req, busy);
            end
        end
        priority_in = 16'hFFFF;
        write_enable(1'b1);
    endtask

    task automatic test_early_done;
        priority_in = 16'd11;
        step;
        irq_ack = 1'b1;
        step;
        irq_ack = 1'b0;
        priority_in = 16'hFFFF;
        step;
        irq_done = 1'b1;
        step;
        irq_done = 1'b0;
        step;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL early_done_service: busy=%b required 1", busy);
        end
        step;
        checks++;
        if (busy !== 1'b0 || wdog_event !== 1'b0) begin
            failures++;
            $display("FAIL early_done_idle: busy=%b wd=%b required 0 0", busy, wdog_event);
        end
    endtask

    task automatic test_watchdog;
        priority_in = 16'd9;
        step;
        irq_ack = 1'b1;
        step;
        irq_ack = 1'b0;
        priority_in = 16'hFFFF;
        step;
        step;
        step;
        for (int i = 0; i <= 16; i++) begin
            checks++;
            if (wdog_event !== (i == 15) || busy !== (i < 15)) begin
                failures++;
                $display("FAIL watchdog cycle %0d: wd=%b busy=%b required %b %b",
                         i, wdog_event, busy, (i == 15), (i < 15));
            end
            step;
        end
    endtask

    task automatic test_random;
        logic [15:0] e;
        logic [15:0] e2;
        logic        have_stale;
        int          ack_dly;
        int          done_dly;
        int          early_pos;
        logic        noise;
        have_stale = 1'b0;
        e2         = 16'd0;
        for (int it = 0; it < 24; it++) begin
            if (have_stale) begin
                e = e2;
            end else begin
                e = 16'($urandom_range(0, 1000));
                priority_in = e;
            end
            step;
            checks++;
            if (irq_req !== 1'b1 || irq_vector !== exp_vec(e) || current_event !== e || busy !== 1'b1) begin
                failures++;
                $display("FAIL rnd_dispatch it %0d: req=%b vec=%h ce=%0d busy=%b required 1 %h %0d 1",
                         it, irq_req, irq_vector, current_event, busy, exp_vec(e), e);
            end
            ack_dly = $urandom_range(0, 4);
            for (int k = 0; k < ack_dly; k++) begin
                step;
                checks++;
                if (irq_req !== 1'b1 || priority_load !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_hold it %0d: req=%b pl=%b required 1 0", it, irq_req, priority_load);
                end
            end
            irq_ack = 1'b1;
            step;
            irq_ack = 1'b0;
            checks++;
            if (priority_load !== 1'b1 || clear_data !== e || irq_req !== 1'b0) begin
                failures++;
                $display("FAIL rnd_clear it %0d: pl=%b cd=%0d req=%b required 1 %0d 0",
                         it, priority_load, clear_data, irq_req, e);
            end
            have_stale = (it < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (have_stale) begin
                e2 = 16'($urandom_range(0, 1000));
                priority_in = e2;
            end else begin
                priority_in = 16'hFFFF;
            end
            if ($urandom_range(0, 1) == 1) begin
                early_pos = $urandom_range(0, 2);
                for (int c = 0; c < 3; c++) begin
                    irq_done = (c == early_pos);
                    step;
                end
                irq_done = 1'b0;
                checks++;
                if (busy !== 1'b1 || irq_req !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_early_service it %0d: busy=%b req=%b required 1 0", it, busy, irq_req);
                end
            end else begin
                step;
                step;
                step;
                noise    = 1'($urandom_range(0, 1));
                irq_ack  = noise;
                done_dly = $urandom_range(0, 8);
                for (int k = 0; k < done_dly; k++) begin
                    step;
                    irq_ack = 1'b0;
                    checks++;
                    if (busy !== 1'b1 || wdog_event !== 1'b0 || irq_req !== 1'b0) begin
                        failures++;
                        $display("FAIL rnd_service it %0d: busy=%b wd=%b req=%b required 1 0 0",
                                 it, busy, wdog_event, irq_req);
                    end
                end
                irq_done = 1'b1;
            end
            step;
            irq_done = 1'b0;
            irq_ack  = 1'b0;
            checks++;
            if (busy !== 1'b0 || wdog_event !== 1'b0 || priority_load !== 1'b0) begin
                failures++;
                $display("FAIL rnd_return it %0d: busy=%b wd=%b pl=%b required 0 0 0",
                         it, busy, wdog_event, priority_load);
            end
        end
    endtask

    task automatic test_reset_in_service;
        priority_in = 16'd13;
        step;
        irq_ack = 1'b1;
        step;
        irq_ack = 1'b0;
        priority_in = 16'hFFFF;
        step;
        step;
        step;
        step;
        sysreset = 1'b1;
        #1;
        checks++;
        if (irq_req !== 1'b0 || irq_vector !== 16'h0000 || priority_load !== 1'b0 ||
            clear_data !== 16'h0000 || current_event !== 16'hFFFF || busy !== 1'b0 ||
            wdog_event !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_service: req=%b vec=%h pl=%b cd=%h ce=%h busy=%b wd=%b required 0 0000 0 0000 ffff 0 0",
                     irq_req, irq_vector, priority_load, clear_data, current_event, busy, wdog_event);
        end
        step;
        sysreset = 1'b0;
        priority_in = 16'd2;
        step;
        step;
        checks++;
        if (irq_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_clears_enable: req=%b required 0", irq_req);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_disabled;
        test_dispatch_stale;
        test_enable_drop;
        test_early_done;
        test_watchdog;
        test_random;
        test_reset_in_service;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
